// File: rtl/down_timer_reload.sv
// Programmable down-counting timer: parallel load, start/stop control,
// prescaled decrement, one-shot or auto-reload operation. Pulses tc for one
// cycle on each terminal decrement. All outputs are registered.
module down_timer_reload #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(PRESCALE) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic [PW-1:0]    psc;

  // Control FSM, counter, prescaler and registered status outputs.
  // Priority per edge: reset > load > stop > start > decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      psc    <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count  <= data;
        reload <= data;
        psc    <= '0;
        state  <= IDLE;
        busy   <= 1'b0;
        done   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // Resume/begin; a zero count never enters RUN.
            if (start && count != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              // Pause: count and prescaler are held for a later resume.
              state <= IDLE;
              busy  <= 1'b0;
            end else if (enable) begin
              if (psc == PW'(PRESCALE - 1)) begin
                psc <= '0;
                if (count == WIDTH'(1)) begin
                  tc <= 1'b1;
                  if (periodic) begin
                    count <= reload;
                  end else begin
                    count <= '0;
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end
                end else if (count != '0) begin
                  count <= count - WIDTH'(1);
                end
              end else begin
                psc <= psc + PW'(1);
              end
            end
          end
          DONE: begin
            // Restart from the saved reload value; a zero reload stays expired.
            if (start) begin
              count <= reload;
              psc   <= '0;
              if (reload != '0) begin
                state <= RUN;
                busy  <= 1'b1;
                done  <= 1'b0;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_timer_reload.sv
// Directed bench for down_timer_reload: two instances (PRESCALE=1 and 3)
// share stimulus; each step checks outputs with immediate assertions.
module tb_down_timer_reload;

  logic       clk = 1'b0;
  logic       reset, load, start, stop, enable, periodic;
  logic [7:0] data;
  logic [7:0] count1, count3;
  logic       tc1, busy1, done1, tc3, busy3, done3;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  down_timer_reload #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .data(data), .load(load), .start(start),
    .stop(stop), .enable(enable), .periodic(periodic),
    .count(count1), .tc(tc1), .busy(busy1), .done(done1));

  down_timer_reload #(.WIDTH(8), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .data(data), .load(load), .start(start),
    .stop(stop), .enable(enable), .periodic(periodic),
    .count(count3), .tc(tc3), .busy(busy3), .done(done3));

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [7:0] c, input logic t,
                      input logic b, input logic d);
    chk({tag, ".count"}, 32'(count1), 32'(c));
    chk({tag, ".tc"},    32'(tc1),    32'(t));
    chk({tag, ".busy"},  32'(busy1),  32'(b));
    chk({tag, ".done"},  32'(done1),  32'(d));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    enable = 1'b0; periodic = 1'b0; data = '0;

    // 1: reset held two cycles, start alone ignored
    step(); step();
    reset = 1'b0;
    chk1("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    chk1("start_at_zero", 8'd0, 1'b0, 1'b0, 1'b0);

    // 2: one-shot count 5 down to 0
    data = 8'd5; load = 1'b1; step(); load = 1'b0;
    chk1("load5", 8'd5, 1'b0, 1'b0, 1'b0);
    enable = 1'b1; periodic = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk1("run5", 8'd5, 1'b0, 1'b1, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk1("oneshot_dec", 8'(i), 1'b0, 1'b1, 1'b0);
    end
    step();
    chk1("oneshot_tc", 8'd0, 1'b1, 1'b0, 1'b1);
    step();
    chk1("oneshot_after", 8'd0, 1'b0, 1'b0, 1'b1);

    // 3: PRESCALE=3 periodic reload of 2 -> tc every 6 cycles
    data = 8'd2; periodic = 1'b1; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("p3_start.count", 32'(count3), 32'd2);
    chk("p3_start.busy",  32'(busy3),  32'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("p3.tc",    32'(tc3),    (k % 6 == 0) ? 32'd1 : 32'd0);
      chk("p3.count", 32'(count3), (k % 6 >= 3) ? 32'd1 : 32'd2);
      chk("p3.busy",  32'(busy3),  32'd1);
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("p3_stop.busy", 32'(busy3), 32'd0);

    // 4: stop after 4 decrements, hold, resume
    periodic = 1'b0;
    data = 8'd10; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk1("run10", 8'd10, 1'b0, 1'b1, 1'b0);
    step(); step(); step(); step();
    chk1("four_dec", 8'd6, 1'b0, 1'b1, 1'b0);
    stop = 1'b1; step(); stop = 1'b0;
    chk1("stopped", 8'd6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("hold", 8'd6, 1'b0, 1'b0, 1'b0);
    end
    start = 1'b1; step(); start = 1'b0;
    chk1("resume", 8'd6, 1'b0, 1'b1, 1'b0);
    for (int i = 5; i >= 1; i--) begin
      step();
      chk1("resume_dec", 8'(i), 1'b0, 1'b1, 1'b0);
    end
    step();
    chk1("resume_tc", 8'd0, 1'b1, 1'b0, 1'b1);

    // 5: same-cycle collisions
    data = 8'd9; load = 1'b1; start = 1'b1; step(); load = 1'b0; start = 1'b0;
    chk1("load_with_start", 8'd9, 1'b0, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    chk1("start9", 8'd9, 1'b0, 1'b1, 1'b0);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk1("stop_wins", 8'd9, 1'b0, 1'b0, 1'b0);
    data = 8'd0; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk1("start_after_load0", 8'd0, 1'b0, 1'b0, 1'b0);

    // 6: reset on the terminal edge suppresses tc; DONE restart from reload
    data = 8'd2; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk1("pre_reset", 8'd1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    chk1("reset_mid_run", 8'd0, 1'b0, 1'b0, 1'b0);
    data = 8'd7; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk1("seven_done", 8'd0, 1'b1, 1'b0, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    chk1("done_restart", 8'd7, 1'b0, 1'b1, 1'b0);
    step();
    chk1("restart_dec", 8'd6, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
